intr_gateway: RTL and testbench

INTR_GATEWAY -- requirements
Module: intr_gateway

---
 rtl/intr_pkg.sv | 20 ++
 rtl/intr_sync_filter.sv | 45 ++++
 rtl/intr_gateway.sv | 134 +++++++++++++
 tb/tb_intr_gateway.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/intr_pkg.sv
// Shared constants for the interrupt gateway: register byte addresses,
// APB FSM state encodings and default sizing.
package intr_pkg;

  localparam int DEFAULT_NUM_INTR  = 16;
  localparam int DEFAULT_INTR_SERV = 4;

  localparam logic [7:0] ADDR_MASK = 8'h00;
  localparam logic [7:0] ADDR_MODE = 8'h02;
  localparam logic [7:0] ADDR_PEND = 8'h04;
  localparam logic [7:0] ADDR_RAW  = 8'h06;
  localparam logic [7:0] ADDR_LAST = 8'h07;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'b001,
    ST_SETUP  = 3'b010,
    ST_ACCESS = 3'b100
  } apb_state_t;

endpackage

// File: rtl/intr_sync_filter.sv
// One interrupt line: 2-flop synchronizer, optionally followed by a
// 3-cycle stability filter when INTR_GATEWAY_FILTER_EN is defined.
module intr_sync_filter (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level
);

  logic [1:0] sync_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[0], raw};
    end
  end

`ifdef INTR_GATEWAY_FILTER_EN
  logic [1:0] cnt_reg;
  logic       filt_reg;

  // The counter tracks how long the synchronized value has disagreed with
  // the filtered one; the third consecutive disagreement flips the output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg  <= '0;
      filt_reg <= 1'b0;
    end else if (sync_reg[1] == filt_reg) begin
      cnt_reg <= '0;
    end else if (cnt_reg == 2'd2) begin
      filt_reg <= sync_reg[1];
      cnt_reg  <= '0;
    end else begin
      cnt_reg <= cnt_reg + 2'd1;
    end
  end

  assign level = filt_reg;
`else
  assign level = sync_reg[1];
`endif

endmodule

// File: rtl/intr_gateway.sv
// APB-programmable interrupt conditioner: per-line sync, edge/level capture,
// masking and service clear. Optional filter: INTR_GATEWAY_FILTER_EN.
module intr_gateway
  import intr_pkg::*;
#(
  parameter int NUM_INTR   = DEFAULT_NUM_INTR,
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int INTR_SERV  = DEFAULT_INTR_SERV
) (
  input  logic                  pclk_i,
  input  logic                  presetn_i,
  input  logic [ADDR_WIDTH-1:0] paddr_i,
  input  logic [DATA_WIDTH-1:0] pwdata_i,
  input  logic                  pwrite_i,
  input  logic                  psel_i,
  input  logic                  penable_i,
  output logic [DATA_WIDTH-1:0] prdata_o,
  output logic                  pready_o,
  output logic                  perror_o,
  input  logic [NUM_INTR-1:0]   irq_raw_i,
  output logic [NUM_INTR-1:0]   intr_active_o,
  input  logic [INTR_SERV-1:0]  intr_to_service_i,
  input  logic                  intr_valid_i,
  input  logic                  intr_serviced_i
);

  apb_state_t          state_reg;
  logic [NUM_INTR-1:0] level, level_d_reg, pend_reg, pend_next, mask_reg, mode_reg;
  logic [NUM_INTR-1:0] rw1c, svc;
  logic [7:0]          addr8, word, wbyte, rbyte;
  logic [15:0]         sel16, wr16, be16;
  logic                oob, xfer, bad, commit, svc_fire;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_INTR; gi++) begin : g_line
      intr_sync_filter u_sync (
        .clk   (pclk_i),
        .rst_n (presetn_i),
        .raw   (irq_raw_i[gi]),
        .level (level[gi])
      );

      // A fresh edge wins over any clear arriving in the same cycle.
      assign svc[gi]       = svc_fire && (intr_to_service_i == INTR_SERV'(gi));
      assign pend_next[gi] = mode_reg[gi]
                           ? ((level[gi] & ~level_d_reg[gi]) |
                              (pend_reg[gi] & ~(rw1c[gi] | svc[gi])))
                           : level[gi];
    end
  endgenerate

  always_comb begin
    addr8  = 8'(paddr_i);
    wbyte  = 8'(pwdata_i);
    word   = {addr8[7:1], 1'b0};
    oob    = paddr_i > ADDR_WIDTH'(ADDR_LAST);
    xfer   = (state_reg == ST_SETUP) && psel_i && penable_i;
    bad    = oob || (pwrite_i && (word == ADDR_RAW));
    commit = xfer && pwrite_i && !bad;
    sel16  = '0;
    case (word)
      ADDR_MASK: sel16 = 16'(mask_reg);
      ADDR_MODE: sel16 = 16'(mode_reg);
      ADDR_PEND: sel16 = 16'(pend_reg);
      ADDR_RAW:  sel16 = 16'(level);
      default:   sel16 = '0;
    endcase
    rbyte    = oob ? 8'h00 : (addr8[0] ? sel16[15:8] : sel16[7:0]);
    wr16     = addr8[0] ? {wbyte, 8'h00} : {8'h00, wbyte};
    be16     = addr8[0] ? 16'hFF00 : 16'h00FF;
    rw1c     = (commit && word == ADDR_PEND) ? wr16[NUM_INTR-1:0] : '0;
    svc_fire = intr_valid_i && intr_serviced_i;
  end

  // Transfers complete on entry to ACCESS: writes commit and the registered
  // response (pready/perror/prdata) is presented during the ACCESS cycle.
  always_ff @(posedge pclk_i or negedge presetn_i) begin
    if (!presetn_i) begin
      state_reg <= ST_IDLE;
      pready_o  <= 1'b0;
      perror_o  <= 1'b0;
      prdata_o  <= '0;
      mask_reg  <= '0;
      mode_reg  <= '0;
    end else begin
      pready_o <= 1'b0;
      perror_o <= 1'b0;
      prdata_o <= '0;
      unique case (state_reg)
        ST_IDLE: begin
          if (psel_i && penable_i) begin
            pready_o <= 1'b1;
            perror_o <= 1'b1;
          end else if (psel_i) begin
            state_reg <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (xfer) begin
            state_reg <= ST_ACCESS;
            pready_o  <= 1'b1;
            perror_o  <= bad;
            if (!pwrite_i && !bad) prdata_o <= DATA_WIDTH'(rbyte);
            if (commit && word == ADDR_MASK)
              mask_reg <= (mask_reg & ~be16[NUM_INTR-1:0]) | wr16[NUM_INTR-1:0];
            if (commit && word == ADDR_MODE)
              mode_reg <= (mode_reg & ~be16[NUM_INTR-1:0]) | wr16[NUM_INTR-1:0];
          end else if (!psel_i) begin
            state_reg <= ST_IDLE;
          end
        end
        ST_ACCESS: begin
          state_reg <= (psel_i && !penable_i) ? ST_SETUP : ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge pclk_i or negedge presetn_i) begin
    if (!presetn_i) begin
      level_d_reg   <= '0;
      pend_reg      <= '0;
      intr_active_o <= '0;
    end else begin
      level_d_reg   <= level;
      pend_reg      <= pend_next;
      intr_active_o <= pend_reg & mask_reg;
    end
  end

endmodule

// File: tb/tb_intr_gateway.sv
// Directed self-checking bench for intr_gateway; covers the filtered build
// when INTR_GATEWAY_FILTER_EN is defined.
module tb_intr_gateway;

  logic        pclk_i = 1'b0;
  logic        presetn_i = 1'b0;
  logic [7:0]  paddr_i = '0;
  logic [7:0]  pwdata_i = '0;
  logic        pwrite_i = 1'b0;
  logic        psel_i = 1'b0;
  logic        penable_i = 1'b0;
  logic [7:0]  prdata_o;
  logic        pready_o;
  logic        perror_o;
  logic [15:0] irq_raw_i = '0;
  logic [15:0] intr_active_o;
  logic [3:0]  intr_to_service_i = '0;
  logic        intr_valid_i = 1'b0;
  logic        intr_serviced_i = 1'b0;

  int errors = 0;
  int checks = 0;
  logic [7:0] rd_data;
  logic       rd_err;

  intr_gateway dut (
    .pclk_i            (pclk_i),
    .presetn_i         (presetn_i),
    .paddr_i           (paddr_i),
    .pwdata_i          (pwdata_i),
    .pwrite_i          (pwrite_i),
    .psel_i            (psel_i),
    .penable_i         (penable_i),
    .prdata_o          (prdata_o),
    .pready_o          (pready_o),
    .perror_o          (perror_o),
    .irq_raw_i         (irq_raw_i),
    .intr_active_o     (intr_active_o),
    .intr_to_service_i (intr_to_service_i),
    .intr_valid_i      (intr_valid_i),
    .intr_serviced_i   (intr_serviced_i)
  );

  always #5 pclk_i = ~pclk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      $error("check %s did not match", tag);
    end
  endtask

  task automatic tick();
    @(posedge pclk_i);
    #1;
  endtask

  // Returns while the DUT sits in ACCESS; the next call may chain straight on.
  task automatic apb(input logic wr, input logic [7:0] a, input logic [7:0] d);
    psel_i = 1'b1; penable_i = 1'b0; pwrite_i = wr; paddr_i = a; pwdata_i = d;
    tick();
    penable_i = 1'b1;
    tick();
    rd_data = prdata_o;
    rd_err  = perror_o;
    check($sformatf("pready_%02h", a), 32'(pready_o), 32'd1);
    psel_i = 1'b0; penable_i = 1'b0; pwrite_i = 1'b0;
    $display("apb %s addr=0x%02h wdata=0x%02h rdata=0x%02h err=%0b",
             wr ? "wr" : "rd", a, d, rd_data, rd_err);
  endtask

  initial begin
    #1;
    check("rst_active", 32'(intr_active_o), 32'h0);
    check("rst_pready", 32'(pready_o), 32'h0);
    check("rst_perror", 32'(perror_o), 32'h0);
    check("rst_prdata", 32'(prdata_o), 32'h0);
    tick(); tick();
    presetn_i = 1'b1;
    tick();

`ifdef INTR_GATEWAY_FILTER_EN
    apb(1, 8'h00, 8'hFF);
    apb(1, 8'h01, 8'hFF);
    apb(1, 8'h02, 8'h02);
    tick();
    irq_raw_i[1] = 1'b1;
    tick(); tick();
    irq_raw_i[1] = 1'b0;
    repeat (10) tick();
    check("glitch_active", 32'(intr_active_o), 32'h0);
    apb(0, 8'h04, 8'h00);
    check("glitch_pend", 32'(rd_data), 32'h00);
    tick(); tick();
    irq_raw_i[1] = 1'b1;
    repeat (4) tick();
    irq_raw_i[1] = 1'b0;
    tick(); tick();
    check("filt_active_e6", 32'(intr_active_o), 32'h0);
    tick();
    check("filt_active_e7", 32'(intr_active_o), 32'h0002);
`else
    // Edge capture of a single-cycle pulse on line 0
    apb(1, 8'h00, 8'hFF);
    check("wr_mask_lo_err", 32'(rd_err), 32'h0);
    apb(1, 8'h01, 8'hFF);
    apb(1, 8'h02, 8'h01);
    apb(1, 8'h03, 8'h00);
    apb(0, 8'h00, 8'h00);
    check("rd_mask_lo", 32'(rd_data), 32'hFF);
    irq_raw_i[0] = 1'b1;
    tick();
    irq_raw_i[0] = 1'b0;
    tick(); tick();
    check("edge_active_e3", 32'(intr_active_o), 32'h0000);
    tick();
    check("edge_active_e4", 32'(intr_active_o), 32'h0001);
    apb(0, 8'h04, 8'h00);
    check("rd_pend_edge", 32'(rd_data), 32'h01);
    apb(0, 8'h02, 8'h00);
    check("rd_mode_lo", 32'(rd_data), 32'h01);

    // Service clear
    tick();
    intr_valid_i = 1'b1; intr_to_service_i = 4'd0; intr_serviced_i = 1'b1;
    tick();
    intr_valid_i = 1'b0; intr_serviced_i = 1'b0;
    tick();
    check("svc_active", 32'(intr_active_o), 32'h0000);
    apb(0, 8'h04, 8'h00);
    check("svc_pend", 32'(rd_data), 32'h00);

    // Level line 3 held while masked, then unmasked, then dropped
    apb(1, 8'h00, 8'h00);
    irq_raw_i[3] = 1'b1;
    repeat (6) tick();
    check("lvl_masked_active", 32'(intr_active_o), 32'h0000);
    apb(0, 8'h06, 8'h00);
    check("rd_raw_lvl", 32'(rd_data), 32'h08);
    apb(0, 8'h04, 8'h00);
    check("rd_pend_masked", 32'(rd_data), 32'h08);
    apb(1, 8'h00, 8'h08);
    check("unmask_active_e0", 32'(intr_active_o), 32'h0000);
    tick();
    check("unmask_active_e1", 32'(intr_active_o), 32'h0008);
    irq_raw_i[3] = 1'b0;
    tick(); tick(); tick();
    check("lvl_drop_e3", 32'(intr_active_o), 32'h0008);
    tick();
    check("lvl_drop_e4", 32'(intr_active_o), 32'h0000);

    // New edge colliding with RW1C on the same bit
    irq_raw_i[0] = 1'b1;
    tick();
    apb(1, 8'h04, 8'h01);
    tick(); tick();
    apb(0, 8'h04, 8'h00);
    check("set_beats_clr", 32'(rd_data), 32'h01);
    apb(1, 8'h04, 8'h01);
    apb(0, 8'h04, 8'h00);
    check("rw1c_clear", 32'(rd_data), 32'h00);
    irq_raw_i[0] = 1'b0;

    // Error responses
    tick(); tick();
    apb(0, 8'h09, 8'h00);
    check("oob_err", 32'(rd_err), 32'h1);
    check("oob_data", 32'(rd_data), 32'h00);
    tick();
    psel_i = 1'b1; penable_i = 1'b1; paddr_i = 8'h00;
    tick();
    check("noset_pready", 32'(pready_o), 32'h1);
    check("noset_perror", 32'(perror_o), 32'h1);
    psel_i = 1'b0; penable_i = 1'b0;
    tick();
    check("noset_pready_drop", 32'(pready_o), 32'h0);
    apb(0, 8'h00, 8'h00);
    check("after_noset_data", 32'(rd_data), 32'h08);
    check("after_noset_err", 32'(rd_err), 32'h0);
    irq_raw_i[2] = 1'b1;
    repeat (4) tick();
    apb(1, 8'h06, 8'hFF);
    check("wr_raw_err", 32'(rd_err), 32'h1);
    apb(0, 8'h06, 8'h00);
    check("raw_unchanged", 32'(rd_data), 32'h04);

    // Reset in the middle of a transfer
    apb(1, 8'h00, 8'h0C);
    tick(); tick();
    check("pre_rst_active", 32'(intr_active_o), 32'h0004);
    psel_i = 1'b1; penable_i = 1'b0; pwrite_i = 1'b1; paddr_i = 8'h01; pwdata_i = 8'hAA;
    tick();
    penable_i = 1'b1;
    #2 presetn_i = 1'b0;
    #1;
    check("async_rst_active", 32'(intr_active_o), 32'h0000);
    check("async_rst_pready", 32'(pready_o), 32'h0);
    psel_i = 1'b0; penable_i = 1'b0; pwrite_i = 1'b0;
    tick(); tick();
    presetn_i = 1'b1;
    tick();
    apb(0, 8'h01, 8'h00);
    check("rst_mask_hi", 32'(rd_data), 32'h00);
    apb(0, 8'h00, 8'h00);
    check("rst_mask_lo", 32'(rd_data), 32'h00);
    apb(0, 8'h04, 8'h00);
    check("rst_pend_level", 32'(rd_data), 32'h04);
`endif

    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
